range_detect_frame_scheduler: RTL
=================================

Name: range_detect_frame_scheduler

Overview:
- Sits in front of the matched-filter range detector and gates paired ADC/DAC IQ frames into it.
- Admits one frame at a time and normalises every admitted frame to exactly FFT_LEN beats: short frames are zero-padded, long frames are truncated.
- Holds off further frames until the detector's peak result is handshaked or a timeout expires.
- Counts forwarded, dropped, padded and truncated frames, timeouts and results for status registers.

Parameters:
FFT_LEN, 4096, beats per frame delivered downstream (power of 2, ≥4)
TIMEOUT_CYCLES, 65536, cycles in WAIT_RESULT before abandoning a frame
CNT_WIDTH, 32, width of each status counter

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
enable  in  1  1 = admit new frames; 0 = finish current frame, admit none
s_adc_tdata  in  32  ADC IQ {I[31:16],Q[15:0]}
s_dac_tdata  in  32  DAC IQ, same beat as ADC
s_tvalid  in  1  input beat valid
s_tlast  in  1  last beat of input frame
s_first  in  1  first beat of input frame
s_tready  out  1  input beat accepted
m_adc_tdata  out  32  to detector ADC path
m_dac_tdata  out  32  to detector DAC path
m_tvalid  out  1  output beat valid
m_tlast  out  1  asserted on beat FFT_LEN-1
m_first  out  1  asserted on beat 0
m_tready  in  1  detector ready
result_tvalid  in  1  detector peak output valid
result_tready  in  1  peak output consumer ready
busy  out  1  state != IDLE
state  out  3  IDLE=0, FORWARD=1, PAD=2, TRUNC=3, WAIT_RESULT=4
frames_forwarded  out  CNT_WIDTH  frames completed to detector
frames_dropped  out  CNT_WIDTH  s_first beats rejected while enabled
frames_padded  out  CNT_WIDTH  short frames zero-padded
frames_truncated  out  CNT_WIDTH  long frames cut
timeouts  out  CNT_WIDTH  WAIT_RESULT timeouts
results  out  CNT_WIDTH  result handshakes seen

Behaviour:
Reset
- areset forces state=IDLE and clears the beat counter, timeout counter and all status counters.
- During reset, m_tvalid=0 and s_tready=0.
- Reset mid-frame abandons the frame; no m_tlast is emitted.

Datapath
- Beat counter width is log2(FFT_LEN).
- Zero latency: m_*data=s_*data, m_tvalid=s_tvalid and s_tready=m_tready while a beat is forwarded.
- An input beat is accepted when s_tvalid&s_tready; an output beat is taken when m_tvalid&m_tready.

IDLE
- If enable&s_tvalid&s_first: forward the beat with m_first=1 and counter=0. On acceptance, go to FORWARD with counter=1.
- If s_tlast is set on that same first beat and FFT_LEN>1, go to PAD instead.
- All other beats: s_tready=1, m_tvalid=0, beat discarded.
- s_first beats with enable=0 are discarded and not counted.

FORWARD
- Pass-through; m_tlast=(counter==FFT_LEN-1); counter increments per accepted beat.
- Accepted beat with s_tlast and counter<FFT_LEN-1: go to PAD, frames_padded++.
- Accepted beat with counter==FFT_LEN-1 and !s_tlast: go to TRUNC, frames_truncated++, frames_forwarded++.
- Accepted beat with counter==FFT_LEN-1 and s_tlast: go to WAIT_RESULT, frames_forwarded++.
- s_first mid-frame is treated as data (no restart).

PAD
- s_tready=0; m_tvalid=1; data=0; counter advances on m_tready.
- At counter==FFT_LEN-1: m_tlast=1. On that handshake go to WAIT_RESULT, frames_forwarded++.

TRUNC
- s_tready=1, m_tvalid=0; beats are discarded until an accepted s_tlast, then go to WAIT_RESULT.

WAIT_RESULT
- s_tready=1; input discarded; timeout counter increments each cycle.
- result_tvalid&result_tready: go to IDLE, results++, timeout counter cleared.
- Timeout counter reaching TIMEOUT_CYCLES-1 without a result: go to IDLE, timeouts++.
- If the result and the timeout occur in the same cycle, the result wins.

Drop counting
- In TRUNC and WAIT_RESULT, accepted s_first beats with enable=1 increment frames_dropped.
- An s_first beat in the same cycle as the exiting result handshake is dropped; frames are admitted only from IDLE.

Other rules
- enable deassert mid-frame has no effect until the next IDLE.
- All counters saturate at all-ones.
- Result handshakes outside WAIT_RESULT are ignored and not counted.

Test Plan:
- FFT_LEN=16: 16-beat frame, tlast on beat 15, then result handshake 5 cycles later → 16 passthrough beats with m_first on beat 0 and m_tlast on beat 15; frames_forwarded=1, results=1, state back to IDLE.
- 10-beat frame with m_tready always 1 → 10 data beats then 6 zero beats with m_tlast on the 16th; s_tready=0 during PAD; frames_padded=1.
- 20-beat frame → beats 0-15 forwarded, beats 16-19 accepted and discarded; frames_truncated=1; state is WAIT_RESULT after beat 19.
- Second frame's s_first arrives during WAIT_RESULT → no m_tvalid; frames_dropped=1. A third frame after the result → forwarded normally.
- TIMEOUT_CYCLES=100, no result → IDLE after 100 cycles, timeouts=1. Repeat with result_tvalid&result_tready on the timeout cycle → results=1, timeouts unchanged.
- Random m_tready backpressure with areset asserted at beat 7 → m_tvalid=0 and all counters 0 immediately. Next frame after reset release → forwarded from beat 0 correctly.

Source files
------------

// File: rtl/range_detect_frame_scheduler.sv
// Frame gate in front of the matched-filter range detector.
// Admits one paired ADC/DAC frame at a time and delivers exactly FFT_LEN
// beats downstream: short frames are zero-padded and long frames truncated.
// It then waits for the detector result or a timeout before admitting the
// next frame. Status counters saturate at all-ones.
module range_detect_frame_scheduler #(
  parameter int unsigned FFT_LEN        = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic [31:0]          s_adc_tdata,
  input  logic [31:0]          s_dac_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  input  logic                 s_first,
  output logic                 s_tready,
  output logic [31:0]          m_adc_tdata,
  output logic [31:0]          m_dac_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_first,
  input  logic                 m_tready,
  input  logic                 result_tvalid,
  input  logic                 result_tready,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] frames_forwarded,
  output logic [CNT_WIDTH-1:0] frames_dropped,
  output logic [CNT_WIDTH-1:0] frames_padded,
  output logic [CNT_WIDTH-1:0] frames_truncated,
  output logic [CNT_WIDTH-1:0] timeouts,
  output logic [CNT_WIDTH-1:0] results
);

  localparam int unsigned CW = $clog2(FFT_LEN);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(FFT_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FORWARD     = 3'd1,
    PAD         = 3'd2,
    TRUNC       = 3'd3,
    WAIT_RESULT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  fwd_q, fwd_d, drop_q, drop_d, pad_q, pad_d;
  logic [CNT_WIDTH-1:0]  trunc_q, trunc_d, tmo_cnt_q, tmo_cnt_d, res_q, res_d;
  logic                  s_acc, m_acc, res_hs, drop_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Zero-latency datapath and handshake steering per state; quiet during reset
  always_comb begin
    m_adc_tdata = '0;
    m_dac_tdata = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_first     = 1'b0;
    s_tready    = 1'b0;
    if (!areset) begin
      case (state_q)
        IDLE: begin
          if (enable && s_tvalid && s_first) begin
            m_adc_tdata = s_adc_tdata;
            m_dac_tdata = s_dac_tdata;
            m_tvalid    = 1'b1;
            m_first     = 1'b1;
            s_tready    = m_tready;
          end else begin
            s_tready = 1'b1;
          end
        end
        FORWARD: begin
          m_adc_tdata = s_adc_tdata;
          m_dac_tdata = s_dac_tdata;
          m_tvalid    = s_tvalid;
          m_tlast     = (cnt_q == BEAT_LAST);
          s_tready    = m_tready;
        end
        PAD: begin
          m_tvalid = 1'b1;
          m_tlast  = (cnt_q == BEAT_LAST);
        end
        TRUNC, WAIT_RESULT: s_tready = 1'b1;
        default: ;
      endcase
    end
  end

  assign s_acc    = s_tvalid & s_tready;
  assign m_acc    = m_tvalid & m_tready;
  assign res_hs   = result_tvalid & result_tready;
  assign drop_hit = s_acc & s_first & enable;

  // Next-state, beat/timeout counters and status counter updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    fwd_d     = fwd_q;
    drop_d    = drop_q;
    pad_d     = pad_q;
    trunc_d   = trunc_q;
    tmo_cnt_d = tmo_cnt_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        // m_first is only raised for an admissible first beat, so m_acc implies s_acc
        if (m_acc && m_first) begin
          cnt_d = CW'(1);
          if (s_tlast) begin
            state_d = PAD;
            pad_d   = sat_inc(pad_q);
          end else begin
            state_d = FORWARD;
          end
        end
      end
      FORWARD: begin
        if (s_acc) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BEAT_LAST) begin
            fwd_d = sat_inc(fwd_q);
            tmo_d = '0;
            if (s_tlast) begin
              state_d = WAIT_RESULT;
            end else begin
              state_d = TRUNC;
              trunc_d = sat_inc(trunc_q);
            end
          end else if (s_tlast) begin
            state_d = PAD;
            pad_d   = sat_inc(pad_q);
          end
        end
      end
      PAD: begin
        if (m_acc) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BEAT_LAST) begin
            state_d = WAIT_RESULT;
            fwd_d   = sat_inc(fwd_q);
            tmo_d   = '0;
          end
        end
      end
      TRUNC: begin
        if (drop_hit) drop_d = sat_inc(drop_q);
        if (s_acc && s_tlast) begin
          state_d = WAIT_RESULT;
          tmo_d   = '0;
        end
      end
      WAIT_RESULT: begin
        if (drop_hit) drop_d = sat_inc(drop_q);
        if (res_hs) begin
          state_d = IDLE;
          res_d   = sat_inc(res_q);
          tmo_d   = '0;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          tmo_d     = '0;
          cnt_d     = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      fwd_q     <= '0;
      drop_q    <= '0;
      pad_q     <= '0;
      trunc_q   <= '0;
      tmo_cnt_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      fwd_q     <= fwd_d;
      drop_q    <= drop_d;
      pad_q     <= pad_d;
      trunc_q   <= trunc_d;
      tmo_cnt_q <= tmo_cnt_d;
      res_q     <= res_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign state            = state_q;
  assign frames_forwarded = fwd_q;
  assign frames_dropped   = drop_q;
  assign frames_padded    = pad_q;
  assign frames_truncated = trunc_q;
  assign timeouts         = tmo_cnt_q;
  assign results          = res_q;

endmodule
